// File: rtl/vga_pkg.sv
// Shared 800x600@72 timing constants, bus widths and small helpers.
// The renderer also uses these values for its layout.
package vga_pkg;
    localparam int H_VISIBLE = 800;
    localparam int H_FP      = 56;
    localparam int H_SYNC    = 120;
    localparam int H_BP      = 64;
    localparam int V_VISIBLE = 600;
    localparam int V_FP      = 37;
    localparam int V_SYNC    = 6;
    localparam int V_BP      = 23;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam int CNT_W       = 11;
    localparam int RGB_FIELD_W = 3;
    localparam int RGB_W       = 3 * RGB_FIELD_W;
    localparam int REG_COUNT   = 11;
    localparam int REG_W       = 16 * REG_COUNT;

    localparam logic             SYNC_POL = 1'b1;
    localparam logic [RGB_W-1:0] FG_RGB   = 9'h1FF;
    localparam logic [RGB_W-1:0] BG_RGB   = 9'h000;

    function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int len);
        return (v >= CNT_W'(lo)) && (v < CNT_W'(lo + len));
    endfunction

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction
endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register of configurable depth; depth 0 is a wire.
module vga_delay_line #(
    parameter int DEPTH = 0,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl_s;
            assign unused_ctrl_s = ^{clk, rst, en};
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // shift one stage per enabled cycle, cleared to inactive on reset
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_r[i] <= {WIDTH{1'b0}};
                end else if (en) begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
                end
            end
            assign q = stage_r[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/vga_scan_controller.sv
// Scan position generator, per-frame register snapshot and
// latency-aligned VGA sync/colour output stage.
module vga_scan_controller #(
    parameter int   H_VISIBLE      = vga_pkg::H_VISIBLE,
    parameter int   H_FP           = vga_pkg::H_FP,
    parameter int   H_SYNC         = vga_pkg::H_SYNC,
    parameter int   H_BP           = vga_pkg::H_BP,
    parameter int   V_VISIBLE      = vga_pkg::V_VISIBLE,
    parameter int   V_FP           = vga_pkg::V_FP,
    parameter int   V_SYNC         = vga_pkg::V_SYNC,
    parameter int   V_BP           = vga_pkg::V_BP,
    parameter logic SYNC_POL       = vga_pkg::SYNC_POL,
    parameter int   RENDER_LATENCY = 0,
    parameter logic [8:0] FG_RGB   = vga_pkg::FG_RGB,
    parameter logic [8:0] BG_RGB   = vga_pkg::BG_RGB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pix_en,
    input  logic [175:0] regs_in,
    input  logic         hit,
    output logic [10:0]  x,
    output logic [10:0]  y,
    output logic [175:0] registers,
    output logic         frame_start,
    output logic         hsync,
    output logic         vsync,
    output logic [8:0]   rgb
);
    import vga_pkg::*;

    localparam int LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] hcnt_r, vcnt_r;
    logic             h_last_s, v_last_s, snap_s;
    logic [2:0]       raw_s, dly_s;
    logic [REG_W-1:0] registers_r;
    logic             frame_start_r, hsync_r, vsync_r;
    logic [RGB_W-1:0] rgb_r;

    assign h_last_s = (hcnt_r == CNT_W'(LINE_LEN - 1));
    assign v_last_s = (vcnt_r == CNT_W'(FRAME_LINES - 1));
    assign snap_s   = pix_en && h_last_s && v_last_s;

    // {visible, hs_raw, vs_raw}, active-high internally
    assign raw_s = {(hcnt_r < CNT_W'(H_VISIBLE)) && (vcnt_r < CNT_W'(V_VISIBLE)),
                    in_window(hcnt_r, H_VISIBLE + H_FP, H_SYNC),
                    in_window(vcnt_r, V_VISIBLE + V_FP, V_SYNC)};

    // horizontal and vertical scan counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_r <= {CNT_W{1'b0}};
            vcnt_r <= {CNT_W{1'b0}};
        end else if (pix_en) begin
            hcnt_r <= h_last_s ? {CNT_W{1'b0}} : hcnt_r + CNT_W'(1);
            if (h_last_s) begin
                vcnt_r <= v_last_s ? {CNT_W{1'b0}} : vcnt_r + CNT_W'(1);
            end
        end
    end

    vga_delay_line #(
        .DEPTH (RENDER_LATENCY),
        .WIDTH (3)
    ) u_align (
        .clk (clk),
        .rst (rst),
        .en  (pix_en),
        .d   (raw_s),
        .q   (dly_s)
    );

    // output stage: hit is sampled alongside the aligned visible flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hsync_r <= ~SYNC_POL;
            vsync_r <= ~SYNC_POL;
            rgb_r   <= {RGB_W{1'b0}};
        end else if (pix_en) begin
            hsync_r <= sync_level(dly_s[1], SYNC_POL);
            vsync_r <= sync_level(dly_s[0], SYNC_POL);
            rgb_r   <= dly_s[2] ? (hit ? FG_RGB : BG_RGB) : {RGB_W{1'b0}};
        end
    end

    // frame snapshot; frame_start is high while the new snapshot is first presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            registers_r   <= {REG_W{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= snap_s;
            if (snap_s) begin
                registers_r <= regs_in;
            end
        end
    end

    assign x           = hcnt_r;
    assign y           = vcnt_r;
    assign registers   = registers_r;
    assign frame_start = frame_start_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign rgb         = rgb_r;
endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller with reduced timing; two instances
// (latency 0 and latency 2) share clock, enable, reset and register inputs.
module tb_vga_scan_controller;
    localparam int HV = 16, HF = 3, HS = 5, HB = 4, HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 2, VB = 3, VT = VV + VF + VS + VB;
    localparam logic [8:0] FG = 9'h1FF;
    localparam logic [8:0] BG = 9'h000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         pix_en = 1'b0;
    logic         hit0 = 1'b0, hit2 = 1'b0;
    logic [175:0] regs_in = '0;
    logic [10:0]  x0, y0, x2, y2;
    logic [175:0] regs0, regs2;
    logic         fs0, fs2, hs0, vs0, hs2, vs2;
    logic [8:0]   rgb0, rgb2;

    vga_scan_controller #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .RENDER_LATENCY(0), .FG_RGB(FG), .BG_RGB(BG)
    ) dut0 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .regs_in(regs_in), .hit(hit0),
        .x(x0), .y(y0), .registers(regs0), .frame_start(fs0),
        .hsync(hs0), .vsync(vs0), .rgb(rgb0)
    );

    vga_scan_controller #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .RENDER_LATENCY(2), .FG_RGB(FG), .BG_RGB(BG)
    ) dut2 (
        .clk(clk), .rst(rst), .pix_en(pix_en), .regs_in(regs_in), .hit(hit2),
        .x(x2), .y(y2), .registers(regs2), .frame_start(fs2),
        .hsync(hs2), .vsync(vs2), .rgb(rgb2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0]  x, y;
        logic         hs0, vs0, hs2, vs2, fs;
        logic [8:0]   rgb0, rgb2;
        logic [175:0] regs;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   k;
    int   checks = 0;
    int   failures = 0;

    // Reference timing expressed directly in terms of enabled-cycle index i.
    function automatic logic vis(input int i);
        return (i >= 0) && ((i % HT) < HV) && (((i / HT) % VT) < VV);
    endfunction
    function automatic logic hsa(input int i);
        return (i >= 0) && ((i % HT) >= HV + HF) && ((i % HT) < HV + HF + HS);
    endfunction
    function automatic logic vsa(input int i);
        return (i >= 0) && (((i / HT) % VT) >= VV + VF) && (((i / HT) % VT) < VV + VF + VS);
    endfunction

    task automatic chk(input string name, input logic [175:0] act, input logic [175:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m.x    = '0; m.y = '0;
        m.hs0  = 1'b0; m.vs0 = 1'b0; m.hs2 = 1'b0; m.vs2 = 1'b0;
        m.rgb0 = '0; m.rgb2 = '0; m.regs = '0; m.fs = 1'b0;
    endtask

    task automatic chk_reset_state();
        chk("rst_x0", x0, 0);       chk("rst_y0", y0, 0);
        chk("rst_x2", x2, 0);       chk("rst_y2", y2, 0);
        chk("rst_hs0", hs0, 0);     chk("rst_vs0", vs0, 0);
        chk("rst_hs2", hs2, 0);     chk("rst_vs2", vs2, 0);
        chk("rst_rgb0", rgb0, 0);   chk("rst_rgb2", rgb2, 0);
        chk("rst_regs0", regs0, 0); chk("rst_regs2", regs2, 0);
        chk("rst_fs0", fs0, 0);     chk("rst_fs2", fs2, 0);
    endtask

    // Predict the state after the coming clock edge, given current inputs.
    task automatic step(input logic en);
        m.fs = en && ((k % HT) == HT - 1) && (((k / HT) % VT) == VT - 1);
        if (en) begin
            if (m.fs) m.regs = regs_in;
            m.hs0  = hsa(k);
            m.vs0  = vsa(k);
            m.rgb0 = vis(k) ? (hit0 ? FG : BG) : 9'h000;
            m.hs2  = hsa(k - 2);
            m.vs2  = vsa(k - 2);
            m.rgb2 = vis(k - 2) ? (hit2 ? FG : BG) : 9'h000;
            k++;
            m.x = 11'(k % HT);
            m.y = 11'((k / HT) % VT);
        end
        q.push_back(m);
    endtask

    // Monitor: compare every presented output cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("x0", x0, e.x);           chk("y0", y0, e.y);
                chk("x2", x2, e.x);           chk("y2", y2, e.y);
                chk("hsync0", hs0, e.hs0);    chk("vsync0", vs0, e.vs0);
                chk("hsync2", hs2, e.hs2);    chk("vsync2", vs2, e.vs2);
                chk("rgb0", rgb0, e.rgb0);    chk("rgb2", rgb2, e.rgb2);
                chk("regs0", regs0, e.regs);  chk("regs2", regs2, e.regs);
                chk("fs0", fs0, e.fs);        chk("fs2", fs2, e.fs);
            end
        end
    end

    // Stimulus driver
    initial begin
        logic en;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_state();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3500) begin
                pix_en = 1'b1;
                #2 rst = 1'b0;
                #1 chk_reset_state();
                repeat (2) @(negedge clk);
                chk_reset_state();
                rst = 1'b1;
                model_reset();
            end
            if (c < 2000)      en = 1'b1;
            else if (c < 3500) en = (c % 2) == 0;
            else               en = 1'(($urandom % 3) != 0);
            if (c < 500)       hit0 = 1'b1;
            else if (c < 1000) hit0 = 1'b0;
            else               hit0 = 1'($urandom);
            hit2 = (k >= 2) && (((k - 2) % HT) == 5);
            if ($urandom_range(0, 79) == 0)
                regs_in = {$urandom, $urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            pix_en = en;
            step(en);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 176'(q.size()), 176'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Display-timing stage directly upstream and downstream of the register-heap renderer. Generates the 800x600 scan position (x, y) fed to the renderer, captures a tear-free snapshot of the CPU register file once per frame as the renderer's 176-bit register bus, and converts the renderer's hit back into sync-aligned VGA colour and sync outputs. Sits between the CPU core and the VGA connector pins.

Parameters:
H_VISIBLE, 800, visible pixels per line
H_FP, 56, horizontal front porch
H_SYNC, 120, hsync pulse width
H_BP, 64, horizontal back porch
V_VISIBLE, 600, visible lines
V_FP, 37, vertical front porch
V_SYNC, 6, vsync pulse width
V_BP, 23, vertical back porch
SYNC_POL, 1, active level of hsync/vsync
RENDER_LATENCY, 0, clocked pixel-enable steps between x/y and a valid hit (0..3)
FG_RGB, 9'h1FF, colour for hit pixels {r3,g3,b3}
BG_RGB, 9'h000, colour for visible non-hit pixels

Ports:
clk  in  1  pixel-domain clock (50 MHz)
rst  in  1  asynchronous, active-low reset
pix_en  in  1  pixel clock enable; all state advances only when high
regs_in  in  176  live register file {r0..r10}, 16 bits each, r0 in [175:160]
hit  in  1  renderer output for the current x/y
x  out  11  horizontal scan position to renderer
y  out  11  vertical scan position to renderer
registers  out  176  per-frame register snapshot to renderer
frame_start  out  1  one-cycle pulse coincident with snapshot capture
hsync  out  1  VGA horizontal sync
vsync  out  1  VGA vertical sync
rgb  out  9  {r[2:0], g[2:0], b[2:0]}

Behaviour:
- H_TOTAL = 1040, V_TOTAL = 666; 72 Hz frame at pix_en = 1.
- hcnt runs 0..H_TOTAL-1 and wraps to 0; vcnt increments on the hcnt wrap and wraps 0 after V_TOTAL-1. Both counters are 11-bit registers.
- x = hcnt, y = vcnt, driven straight from the registers, including during blanking.
- visible = (hcnt < H_VISIBLE) && (vcnt < V_VISIBLE).
- hs_raw is active for hcnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), which is 856..975. vs_raw is active for vcnt in [V_VISIBLE+V_FP, +V_SYNC), which is 637..642, for the whole line.
- Alignment: visible, hs_raw and vs_raw pass through a RENDER_LATENCY-deep shift register, advancing only on pix_en. One output register stage follows. hit is sampled at that same output stage.
- Total latency is RENDER_LATENCY+1 enabled cycles from a counter value to its hsync/vsync/rgb.
- rgb = 0 when delayed visible = 0; otherwise FG_RGB if hit, else BG_RGB.
- Snapshot: at the enabled edge where hcnt = H_TOTAL-1 and vcnt = V_TOTAL-1:
  - registers <= regs_in;
  - frame_start = 1 for that one enabled cycle, otherwise 0.
  - registers is constant for the entire frame. Changes to regs_in mid-frame appear only after the next capture.
- pix_en = 0: counters, pipeline, outputs and registers all hold. frame_start holds 0.
- Reset (rst = 0, asynchronous):
  - hcnt = vcnt = 0; pipeline cleared to invisible/inactive;
  - hsync = vsync = ~SYNC_POL; rgb = 0; registers = 0; frame_start = 0.
  - Deassertion mid-line restarts scanning at (0,0). No partial pulse is produced.
- Simultaneous hcnt and vcnt wrap coincides with the snapshot edge. The next enabled cycle shows x = 0, y = 0 with the new registers.

Decomposition:
- Shared package vga_pkg holds the timing constants, H_TOTAL/V_TOTAL derivation and the rgb field widths. The renderer reuses these constants for layout.
- One natural sub-module is vga_delay_line: a parameterised-depth, enable-gated shift register used for the visible, hs and vs alignment.

Test Plan:
- Reset asserted mid-frame: outputs show hsync = vsync = 0 (SYNC_POL = 1), rgb = 0, registers = 0. After release, x = 0, y = 0, then x increments by 1 per enabled cycle.
- Line and frame timing, L = 0, pix_en = 1: hsync high for exactly 120 cycles, starting 857 cycles after the line starts. Line period is 1040 cycles. vsync is high for 6×1040 cycles. Frame period is 692640 cycles.
- hit tied 1: rgb = 9'h1FF exactly for the 800×600 visible window, delayed 1 cycle, and 0 throughout blanking. hit tied 0: rgb = 0 everywhere.
- Snapshot: set regs_in = A before frame_start, then B at y = 300. registers = A for the whole frame. registers changes to B at the next frame_start, and frame_start pulses exactly once per 692640 cycles.
- RENDER_LATENCY = 2, hit driven as a 2-cycle-delayed (x == 5) decode: rgb = FG only at the output slot for x = 5. hsync rises 3 cycles after hcnt = 856.
- pix_en toggled 1/0 alternately: every timing figure doubles, and no output changes on cycles where pix_en = 0.
